// File: rtl/seq_fsm_ctrl.sv
// seq_fsm_ctrl: start-triggered sequencer. It walks through NUM_STAGES
// condition-gated stages (each one strict or patient), then waits in HOLD
// until it is released. Progress is shown as a thermometer code. The block
// pulses done on HOLD entry and fail on a failed return to IDLE, and it keeps
// a sticky fail_code. All outputs come from registers, so no input reaches
// an output combinationally.
module seq_fsm_ctrl #(
  parameter int                    NUM_STAGES  = 3,
  parameter logic [NUM_STAGES-1:0] STRICT_MASK = NUM_STAGES'(1),
  parameter int                    TO_W        = 8,
  parameter int                    TO_CYC      = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [NUM_STAGES-1:0] cond_i,
  input  logic                  release_i,
  input  logic                  abort_req_i,
  output logic                  busy_o,
  output logic [NUM_STAGES:0]   therm_o,
  output logic [3:0]            state_id_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [1:0]            fail_code_o
);

  // Stage k is encoded as 2+k. Only the first stage is named. The other
  // stages are reached by stepping the encoding.
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ARM    = 4'd1,
    S_STAGE0 = 4'd2,
    S_HOLD   = 4'(NUM_STAGES + 2)
  } state_e;

  localparam bit             TO_EN   = (TO_CYC != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TO_CYC - 1) : '0;

  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_STRICT = 2'b01;
  localparam logic [1:0] CODE_TMO    = 2'b10;
  localparam logic [1:0] CODE_ABORT  = 2'b11;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;
  logic [1:0]      code_q, code_d;

  // Per-stage view of the current state: is this a stage, which condition
  // applies, is the stage strict, and is it the last one.
  logic in_stage, cond_sel, strict_sel, last_sel;

  // Select the condition and mode for whichever stage is active.
  always_comb begin
    in_stage   = 1'b0;
    cond_sel   = 1'b0;
    strict_sel = 1'b0;
    last_sel   = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (4'(state_q) == 4'(k + 2)) begin
        in_stage   = 1'b1;
        cond_sel   = cond_i[k];
        strict_sel = STRICT_MASK[k];
        last_sel   = (k == NUM_STAGES - 1);
      end
    end
  end

  // Next-state, wait counter and pulse/code logic. Priority is:
  // illegal state, then abort, then cond/timeout, then release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    code_d  = code_q;
    if (state_q == S_IDLE) begin
      if (start_i) begin
        state_d = S_ARM;
        code_d  = CODE_NONE;
        cnt_d   = '0;
      end
    end else if (!(state_q == S_ARM || state_q == S_HOLD || in_stage)) begin
      // An unreachable encoding returns silently to IDLE.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (abort_req_i) begin
      state_d = S_IDLE;
      fail_d  = 1'b1;
      code_d  = CODE_ABORT;
      cnt_d   = '0;
    end else if (state_q == S_ARM) begin
      state_d = S_STAGE0;
      cnt_d   = '0;
    end else if (in_stage) begin
      if (cond_sel) begin
        state_d = last_sel ? S_HOLD : state_e'(4'(state_q) + 4'd1);
        done_d  = last_sel;
        cnt_d   = '0;
      end else if (strict_sel) begin
        state_d = S_IDLE;
        fail_d  = 1'b1;
        code_d  = CODE_STRICT;
        cnt_d   = '0;
      end else if (TO_EN && (cnt_q == TO_LAST)) begin
        state_d = S_IDLE;
        fail_d  = 1'b1;
        code_d  = CODE_TMO;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end else begin
      // HOLD: start is ignored here, so only release matters.
      if (release_i) begin
        state_d = S_IDLE;
      end
    end
  end

  // State, counter and registered pulse/code outputs, with async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= CODE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
    end
  end

  // Thermometer length: ARM lights 1 bit, stage k lights k+1, HOLD lights all.
  logic [4:0] therm_len;

  // Moore decode of progress from the state register only.
  always_comb begin
    therm_len = 5'd0;
    if (state_q == S_ARM) begin
      therm_len = 5'd1;
    end else if (in_stage || state_q == S_HOLD) begin
      therm_len = 5'(state_q) - 5'd1;
    end
    for (int j = 0; j <= NUM_STAGES; j++) begin
      therm_o[j] = (5'(j) < therm_len);
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign state_id_o  = state_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_code_o = code_q;

endmodule

// File: tb/tb_seq_fsm_ctrl.sv
// Bench for seq_fsm_ctrl (3 stages, stage 0 strict, TO_CYC=4). It drives a
// table of per-cycle vectors. Each expected output is queued when its vector
// is driven and checked one clock later. Hand-written checks cover reset and
// the async reset taken in the middle of a cycle.
module tb_seq_fsm_ctrl;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [N-1:0] cond_i = '0;
  logic         release_i = 1'b0;
  logic         abort_req_i = 1'b0;
  logic         busy_o;
  logic [N:0]   therm_o;
  logic [3:0]   state_id_o;
  logic         done_o;
  logic         fail_o;
  logic [1:0]   fail_code_o;

  seq_fsm_ctrl #(
    .NUM_STAGES (N),
    .STRICT_MASK(3'b001),
    .TO_W       (8),
    .TO_CYC     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .cond_i     (cond_i),
    .release_i  (release_i),
    .abort_req_i(abort_req_i),
    .busy_o     (busy_o),
    .therm_o    (therm_o),
    .state_id_o (state_id_o),
    .done_o     (done_o),
    .fail_o     (fail_o),
    .fail_code_o(fail_code_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [3:0] sid;
    logic [3:0] th;
    logic       dn;
    logic       fl;
    logic [1:0] fc;
  } exp_t;

  typedef struct packed {
    logic         st;
    logic [N-1:0] cnd;
    logic         rl;
    logic         ab;
    exp_t         exp;
  } vec_t;

  localparam int NV = 45;
  vec_t vecs[NV];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic st, input logic [N-1:0] cnd,
                              input logic rl, input logic ab,
                              input logic [3:0] sid, input logic [3:0] th,
                              input logic dn, input logic fl,
                              input logic [1:0] fc);
    vec_t v;
    v.st = st; v.cnd = cnd; v.rl = rl; v.ab = ab;
    v.exp.busy = (sid != 4'd0);
    v.exp.sid = sid; v.exp.th = th; v.exp.dn = dn; v.exp.fl = fl; v.exp.fc = fc;
    return v;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.busy = busy_o; a.sid = state_id_o; a.th = therm_o;
    a.dn = done_o; a.fl = fail_o; a.fc = fail_code_o;
    return a;
  endfunction

  task automatic compare(input string name, input exp_t exp);
    exp_t act;
    act = actual();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got busy=%b sid=%0d therm=%b done=%b fail=%b code=%b, want busy=%b sid=%0d therm=%b done=%b fail=%b code=%b",
               name, act.busy, act.sid, act.th, act.dn, act.fl, act.fc,
               exp.busy, exp.sid, exp.th, exp.dn, exp.fl, exp.fc);
    end else begin
      $display("vec %s: sid=%0d therm=%b done=%b fail=%b code=%b",
               name, act.sid, act.th, act.dn, act.fl, act.fc);
    end
  endtask

  // Drive one vector, queue its expectation, then check it after the edge.
  task automatic apply(input int idx);
    exp_t e;
    start_i     = vecs[idx].st;
    cond_i      = vecs[idx].cnd;
    release_i   = vecs[idx].rl;
    abort_req_i = vecs[idx].ab;
    sb_q.push_back(vecs[idx].exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL v%0d: scoreboard empty, got sid=%0d want a queued entry", idx, state_id_o);
    end else begin
      e = sb_q.pop_front();
      compare($sformatf("v%0d", idx), e);
    end
  endtask

  initial begin
    exp_t zero_e;
    zero_e = '0;

    // Happy path: ARM, STAGE0..2, HOLD with done; start in HOLD is ignored.
    vecs[0]  = mk(1, 3'b111, 0, 0, 4'd1, 4'b0001, 0, 0, 2'b00);
    vecs[1]  = mk(0, 3'b111, 0, 0, 4'd2, 4'b0001, 0, 0, 2'b00);
    vecs[2]  = mk(0, 3'b111, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[3]  = mk(0, 3'b111, 0, 0, 4'd4, 4'b0111, 0, 0, 2'b00);
    vecs[4]  = mk(0, 3'b111, 0, 0, 4'd5, 4'b1111, 1, 0, 2'b00);
    vecs[5]  = mk(1, 3'b111, 0, 0, 4'd5, 4'b1111, 0, 0, 2'b00);
    vecs[6]  = mk(0, 3'b000, 1, 0, 4'd0, 4'b0000, 0, 0, 2'b00);
    // Strict miss on stage 0; an abort while IDLE changes nothing.
    vecs[7]  = mk(1, 3'b000, 0, 0, 4'd1, 4'b0001, 0, 0, 2'b00);
    vecs[8]  = mk(0, 3'b000, 0, 0, 4'd2, 4'b0001, 0, 0, 2'b00);
    vecs[9]  = mk(0, 3'b000, 0, 0, 4'd0, 4'b0000, 0, 1, 2'b01);
    vecs[10] = mk(0, 3'b000, 0, 0, 4'd0, 4'b0000, 0, 0, 2'b01);
    vecs[11] = mk(0, 3'b000, 0, 1, 4'd0, 4'b0000, 0, 0, 2'b01);
    // Timeout in patient stage 1: four cycles, then fail with code 10.
    vecs[12] = mk(1, 3'b001, 0, 0, 4'd1, 4'b0001, 0, 0, 2'b00);
    vecs[13] = mk(0, 3'b001, 0, 0, 4'd2, 4'b0001, 0, 0, 2'b00);
    vecs[14] = mk(0, 3'b001, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[15] = mk(0, 3'b001, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[16] = mk(0, 3'b001, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[17] = mk(0, 3'b001, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[18] = mk(0, 3'b001, 0, 0, 4'd0, 4'b0000, 0, 1, 2'b10);
    vecs[19] = mk(0, 3'b001, 0, 0, 4'd0, 4'b0000, 0, 0, 2'b10);
    // cond[1] rises on the 4th cycle of stage 1: advance, no fail.
    vecs[20] = mk(1, 3'b001, 0, 0, 4'd1, 4'b0001, 0, 0, 2'b00);
    vecs[21] = mk(0, 3'b001, 0, 0, 4'd2, 4'b0001, 0, 0, 2'b00);
    vecs[22] = mk(0, 3'b001, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[23] = mk(0, 3'b001, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[24] = mk(0, 3'b001, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[25] = mk(0, 3'b001, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[26] = mk(0, 3'b011, 0, 0, 4'd4, 4'b0111, 0, 0, 2'b00);
    // Abort beats cond[2] in stage 2: no done, code 11.
    vecs[27] = mk(0, 3'b111, 0, 1, 4'd0, 4'b0000, 0, 1, 2'b11);
    vecs[28] = mk(0, 3'b000, 0, 0, 4'd0, 4'b0000, 0, 0, 2'b11);
    // HOLD: start ignored; start together with release is not accepted.
    vecs[29] = mk(1, 3'b111, 0, 0, 4'd1, 4'b0001, 0, 0, 2'b00);
    vecs[30] = mk(0, 3'b111, 0, 0, 4'd2, 4'b0001, 0, 0, 2'b00);
    vecs[31] = mk(0, 3'b111, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[32] = mk(0, 3'b111, 0, 0, 4'd4, 4'b0111, 0, 0, 2'b00);
    vecs[33] = mk(0, 3'b111, 0, 0, 4'd5, 4'b1111, 1, 0, 2'b00);
    vecs[34] = mk(1, 3'b111, 0, 0, 4'd5, 4'b1111, 0, 0, 2'b00);
    vecs[35] = mk(1, 3'b111, 1, 0, 4'd0, 4'b0000, 0, 0, 2'b00);
    vecs[36] = mk(1, 3'b111, 0, 0, 4'd1, 4'b0001, 0, 0, 2'b00);
    vecs[37] = mk(0, 3'b000, 0, 0, 4'd2, 4'b0001, 0, 0, 2'b00);
    vecs[38] = mk(0, 3'b011, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    // After the async reset: a full sequence runs normally.
    vecs[39] = mk(1, 3'b111, 0, 0, 4'd1, 4'b0001, 0, 0, 2'b00);
    vecs[40] = mk(0, 3'b111, 0, 0, 4'd2, 4'b0001, 0, 0, 2'b00);
    vecs[41] = mk(0, 3'b111, 0, 0, 4'd3, 4'b0011, 0, 0, 2'b00);
    vecs[42] = mk(0, 3'b111, 0, 0, 4'd4, 4'b0111, 0, 0, 2'b00);
    vecs[43] = mk(0, 3'b111, 0, 0, 4'd5, 4'b1111, 1, 0, 2'b00);
    vecs[44] = mk(0, 3'b000, 1, 0, 4'd0, 4'b0000, 0, 0, 2'b00);

    // Reset state while rst_n is held low.
    #12;
    compare("reset", zero_e);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare("idle_after_reset", zero_e);

    for (int i = 0; i <= 38; i++) begin
      apply(i);
    end

    // The DUT is now in STAGE 1. Drop rst_n between edges; the outputs must
    // clear before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    compare("async_reset", zero_e);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare("idle_after_async", zero_e);

    for (int i = 39; i < NV; i++) begin
      apply(i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
